// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron spike interface: drain FSM states, default
// sizing constants and the channel-index width rule used by encoder and decoder.
package neuron_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    localparam int NUM_CH_DEF      = 4;
    localparam int WINDOW_LOG2_DEF = 8;
    localparam int CNT_W_DEF       = 8;

    // Both ends of the spike link must size spike_ch identically.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Rate readout stream of the spike rate decoder: one (channel, rate) entry per
// valid/ready transfer. The decoder is the master, the consumer the slave.
interface spike_rate_decoder_if #(
    parameter int NUM_CH = neuron_pkg::NUM_CH_DEF,
    parameter int CNT_W  = neuron_pkg::CNT_W_DEF
) ();
    localparam int CH_W = neuron_pkg::ch_idx_w(NUM_CH);

    logic             rate_valid;
    logic             rate_ready;
    logic [CH_W-1:0]  rate_ch;
    logic [CNT_W-1:0] rate;

    modport master (output rate_valid, output rate_ch, output rate, input rate_ready);
    modport slave  (input rate_valid, input rate_ch, input rate, output rate_ready);

endinterface

// File: rtl/spike_rate_decoder_sat_counter.sv
// Per-channel saturating spike counter with synchronous clear (boxcar window)
// and synchronous halve (leaky window), both applied to the post-increment value.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             halve,
    output logic [CNT_W-1:0] cnt_next
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;

    // Count including this cycle's spike; the snapshot samples this so a spike
    // on the last window cycle still belongs to the ending window.
    assign cnt_next = (inc && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (halve) begin
            cnt_q <= cnt_next >> 1;
        end else begin
            cnt_q <= cnt_next;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Converts time-multiplexed spike events into per-channel spikes-per-window rates,
// streamed out one channel at a time. LEAKY_DECODE_EN: halve instead of clear at window end.
module spike_rate_decoder
    import neuron_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int WINDOW_LOG2 = WINDOW_LOG2_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    localparam int CH_W       = ch_idx_w(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spike_valid,
    input  logic [CH_W-1:0]        spike_ch,
    output logic                   overrun,
    spike_rate_decoder_if.master   rate_if
);

`ifdef LEAKY_DECODE_EN
    localparam bit LEAKY = 1'b1;
`else
    localparam bit LEAKY = 1'b0;
`endif

    logic [WINDOW_LOG2-1:0] win_cnt_q;
    logic                   wend;
    logic [CNT_W-1:0]       live_next [NUM_CH];
    logic [CNT_W-1:0]       snap_q    [NUM_CH];
    drain_state_e           state_q, state_d;
    logic [CH_W-1:0]        idx_q, idx_d;
    logic                   capture;
    logic                   accept;
    logic                   overrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_q + 1'b1;
        end
    end

    assign wend = &win_cnt_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_live
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (spike_valid && (spike_ch == CH_W'(i))),
            .clr      (wend && !LEAKY),
            .halve    (wend && LEAKY),
            .cnt_next (live_next[i])
        );
    end

    assign accept = (state_q == DRAIN) && rate_if.rate_ready;

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (wend) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                    capture = 1'b1;
                end
            end
            DRAIN: begin
                if (accept) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == CH_W'(NUM_CH - 1)) begin
                        state_d = ACCUM;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (wend && (state_q == DRAIN)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // NOTE: the snapshot buffer is reset explicitly so an abandoned drain leaves
    // no stale rates behind; it is small enough to live in flops, not RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_q[i] <= live_next[i];
            end
        end
    end

    // All outputs come straight from registers; rate_ready only steers next state.
    assign rate_if.rate_valid = (state_q == DRAIN);
    assign rate_if.rate_ch    = idx_q;
    assign rate_if.rate       = snap_q[idx_q];
    assign overrun            = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: a cycle model predicts each window
// snapshot into a scoreboard queue that is compared as entries are presented.
module tb_spike_rate_decoder;
    import neuron_pkg::*;

    localparam int NUM_CH      = 4;
    localparam int WINDOW_LOG2 = 8;
    localparam int CNT_W       = 8;
    localparam int CH_W        = ch_idx_w(NUM_CH);
    localparam int WIN         = 1 << WINDOW_LOG2;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef LEAKY_DECODE_EN
    localparam bit LEAKY = 1'b1;
`else
    localparam bit LEAKY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            spike_valid = 1'b0;
    logic [CH_W-1:0] spike_ch = '0;
    logic            overrun;

    spike_rate_decoder_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) rate_if ();

    spike_rate_decoder #(
        .NUM_CH      (NUM_CH),
        .WINDOW_LOG2 (WINDOW_LOG2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spike_valid (spike_valid),
        .spike_ch    (spike_ch),
        .overrun     (overrun),
        .rate_if     (rate_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int rate;
    } entry_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    entry_t exp_q[$];
    int     m_win;
    int     m_live [NUM_CH];
    bit     m_drain;
    bit     m_overrun;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input bit inc);
        return (inc && (v < CNT_MAX)) ? v + 1 : v;
    endfunction

    // One clock cycle: drive inputs, check outputs, then advance the model.
    task automatic tick(input bit sv, input int ch, input bit rdy);
        bit wend;
        bit accept;
        int nxt;
        entry_t e;
        spike_valid        = sv;
        spike_ch           = CH_W'(ch);
        rate_if.rate_ready = rdy;
        #1;
        check("rate_valid", {31'b0, rate_if.rate_valid}, {31'b0, m_drain});
        check("overrun", {31'b0, overrun}, {31'b0, m_overrun});
        accept = rate_if.rate_valid && rdy;
        if (rate_if.rate_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_entry", exp_q.size(), 1);
            end else begin
                check("rate_ch", {{(32-CH_W){1'b0}}, rate_if.rate_ch}, exp_q[0].ch);
                check("rate", {{(32-CNT_W){1'b0}}, rate_if.rate}, exp_q[0].rate);
            end
        end
        @(posedge clk);
        wend = (m_win == WIN - 1);
        if (wend && m_drain) m_overrun = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            nxt = sat_inc(m_live[c], sv && (ch == c));
            if (wend && !m_drain) begin
                e.ch   = c;
                e.rate = nxt;
                exp_q.push_back(e);
            end
            m_live[c] = wend ? (LEAKY ? (nxt >> 1) : 0) : nxt;
        end
        if (accept && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_drain = 1'b0;
        end
        if (wend && exp_q.size() > 0) m_drain = 1'b1;
        m_win = (m_win + 1) % WIN;
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n              = 1'b0;
        spike_valid        = 1'b0;
        rate_if.rate_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        m_win     = 0;
        m_drain   = 1'b0;
        m_overrun = 1'b0;
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) m_live[c] = 0;
        #1;
        check("rst_rate_valid", {31'b0, rate_if.rate_valid}, 0);
        check("rst_rate_ch", {{(32-CH_W){1'b0}}, rate_if.rate_ch}, 0);
        check("rst_rate", {{(32-CNT_W){1'b0}}, rate_if.rate}, 0);
        check("rst_overrun", {31'b0, overrun}, 0);
    endtask

    // Idle until the next tick lands on the window-end cycle.
    task automatic idle_until_wend(input bit rdy);
        for (int i = 0; i < WIN && m_win != WIN - 1; i++) tick(1'b0, 0, rdy);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 4 * NUM_CH && m_drain; i++) tick(1'b0, 0, 1'b1);
        #1;
        check("drain_done", {31'b0, rate_if.rate_valid}, 0);
    endtask

    initial begin
        rate_if.rate_ready = 1'b0;
        do_reset(2);

        // Channel 2 every cycle for a full window saturates at CNT_MAX.
        for (int i = 0; i < WIN; i++) tick(1'b1, 2, 1'b1);
        drain_all();

        // Mixed counts on ch0/ch1 with an always-ready consumer.
        for (int i = 0; i < 10; i++) tick(1'b1, 0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1, 1'b1);
        idle_until_wend(1'b1);
        tick(1'b0, 0, 1'b1);
        drain_all();

        // Spike exactly on the window-end cycle, then an empty window.
        idle_until_wend(1'b1);
        tick(1'b1, 1, 1'b1);
        drain_all();
        idle_until_wend(1'b1);
        tick(1'b0, 0, 1'b1);
        drain_all();

        // Stalled consumer across two window ends raises overrun.
        for (int i = 0; i < 5; i++) tick(1'b1, 3, 1'b1);
        idle_until_wend(1'b0);
        tick(1'b0, 0, 1'b0);
        for (int i = 0; i < WIN + 8; i++) tick((i % 3) == 0, i % NUM_CH, 1'b0);
        drain_all();

        // Reset while entry 1 is presented.
        idle_until_wend(1'b1);
        tick(1'b1, 3, 1'b1);
        tick(1'b0, 0, 1'b1);
        tick(1'b1, 2, 1'b0);
        do_reset(1);
        for (int i = 0; i < 7; i++) tick(1'b1, 2, 1'b1);
        idle_until_wend(1'b1);
        tick(1'b0, 0, 1'b1);
        drain_all();

        // 40 spikes then a silent window (20 carried over in leaky mode).
        for (int i = 0; i < 40; i++) tick(1'b1, 3, 1'b1);
        idle_until_wend(1'b1);
        tick(1'b0, 0, 1'b1);
        drain_all();
        idle_until_wend(1'b1);
        tick(1'b0, 0, 1'b1);
        drain_all();

        check("queue_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
